// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with req/gnt/rvalid handshake and load formatting
module mem_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  input  logic [2:0]       funct3M,
  input  logic             memwriteM,
  input  logic [1:0]       resultsrcM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] readdataM,
  output logic             stallM,
  output logic             faultM
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off;
  logic        st, ld, acc, ill, mis, go;
  logic [31:0] sh, ld_fmt, st_data;
  logic [3:0]  st_be;
  state_t      gnt_nxt;
  assign off      = aluresultM[1:0];
  assign st       = memwriteM;
  assign ld       = (resultsrcM == 2'b01) && !memwriteM;
  assign acc      = st || ld;
  assign ill      = st ? (funct3M[2] || funct3M[1:0] == 2'b11)
                       : (funct3M == 3'b011 || funct3M[2:1] == 2'b11);
  assign mis      = (funct3M[1:0] == 2'b01 && off[0]) || (funct3M[1:0] == 2'b10 && off != 2'b00);
  assign go       = acc && !ill && !mis;
  assign gnt_nxt  = st ? DONE : WAIT;
  assign dmem_addr = {aluresultM[31:2], 2'b00};
  assign st_data  = funct3M[1:0] == 2'b00 ? {4{writedataM[7:0]}} :
                    funct3M[1:0] == 2'b01 ? {2{writedataM[15:0]}} : writedataM;
  assign st_be    = funct3M[1:0] == 2'b00 ? 4'b0001 << off :
                    funct3M[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign sh       = rdata_q >> {off, 3'b000};
  assign ld_fmt   = funct3M == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                    funct3M == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                    funct3M == 3'b100 ? {24'd0, sh[7:0]} :
                    funct3M == 3'b101 ? {16'd0, sh[15:0]} : rdata_q;
  assign dmem_we    = dmem_req && st;
  assign dmem_wdata = dmem_we ? st_data : '0;
  assign dmem_be    = dmem_we ? st_be : 4'b0000;
  assign readdataM  = (state_q == DONE && ld && !rst) ? ld_fmt : '0;
  // State and captured read word
  always_ff @(posedge clk) begin
    state_q <= state_d;
    rdata_q <= rdata_d;
  end
  // Handshake sequencing, stall and fault generation; reset overrides everything
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    dmem_req = 1'b0;
    stallM   = 1'b0;
    faultM   = 1'b0;
    case (state_q)
      IDLE: begin
        faultM   = acc && !go;
        dmem_req = go;
        stallM   = go;
        state_d  = go ? (dmem_gnt ? gnt_nxt : REQ) : IDLE;
      end
      REQ: begin
        dmem_req = 1'b1;
        stallM   = 1'b1;
        state_d  = dmem_gnt ? gnt_nxt : REQ;
      end
      WAIT: begin
        stallM  = 1'b1;
        rdata_d = dmem_rvalid ? dmem_rdata : rdata_q;
        state_d = dmem_rvalid ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d  = IDLE;
      rdata_d  = '0;
      dmem_req = 1'b0;
      stallM   = 1'b0;
      faultM   = 1'b0;
    end
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit, downstream of the EX/MEM pipeline register.
- Consumes the MEM-stage address, store data, funct3 and control signals.
- Runs a request/grant/response handshake with the data memory and formats load data for writeback.
- Stalls the pipeline until each access completes.

Parameters:
WIDTH, 32, data/address width; only 32 is supported (byte-lane logic is fixed at 4 lanes).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
aluresultM  input  WIDTH  byte address of the access
writedataM  input  WIDTH  store data (rs2 value)
funct3M  input  3  access size/sign
memwriteM  input  1  store in MEM stage
resultsrcM  input  2  2'b01 marks a load in MEM stage
dmem_req  output  1  request to data memory
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  WIDTH  word-aligned address, {aluresultM[31:2],2'b00}
dmem_wdata  output  WIDTH  lane-replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  memory accepts request this cycle
dmem_rvalid  input  1  read data valid this cycle
dmem_rdata  input  WIDTH  raw read word
readdataM  output  WIDTH  aligned, extended load result
stallM  output  1  freeze IF..MEM; EX/MEM register holds
faultM  output  1  misaligned or illegal-funct3 access

Behaviour:
- Access decode:
  - load = (resultsrcM==2'b01); store = memwriteM.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
- Fault (combinational, IDLE only):
  - Conditions: illegal funct3; halfword with off[0]=1; word with off!=0; off = aluresultM[1:0].
  - Response: faultM=1 for that cycle, no dmem_req, stallM=0, readdataM=0.
- State machine IDLE/REQ/WAIT/DONE; reset state IDLE.
  - IDLE, legal access: dmem_req=1, stallM=1.
    - gnt with store -> DONE.
    - gnt with load -> WAIT.
    - no gnt -> REQ.
  - IDLE, no access: stallM=0.
  - REQ: dmem_req held at 1 with addr/we/wdata/be stable, stallM=1; same gnt transitions as IDLE.
  - WAIT: dmem_req=0, stallM=1; on dmem_rvalid, capture dmem_rdata into rdata_q and go to DONE.
  - DONE: dmem_req=0, stallM=0, pipeline advances at the end of this cycle; next state IDLE. No new request is issued from DONE, so a held instruction is never re-issued.
- MEM-stage inputs are stable while stallM=1. The unit relies on this and does not latch address or funct3.
- Store encoding:
  - SB: wdata={4{wd[7:0]}}, be=4'b0001<<off.
  - SH: wdata={2{wd[15:0]}}, be=4'b0011<<off.
  - SW: wdata=wd, be=4'b1111.
  - dmem_we=1.
- Load formatting (readdataM, valid in DONE only, 0 otherwise):
  - Select the byte/half of rdata_q at off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Ignored inputs:
  - dmem_rvalid outside WAIT.
  - dmem_gnt outside IDLE/REQ.
  - A load with memwriteM also set is treated as a store.
- Minimum latency, cycles in MEM:
  - Store: 2 (IDLE+DONE).
  - Load with immediate gnt and rvalid next cycle: 3 (IDLE, WAIT, DONE).
- Reset (sync, any state, including mid-REQ/WAIT): state IDLE, rdata_q=0. Outputs that cycle: dmem_req=0, stallM=0, faultM=0, readdataM=0. A later stray rvalid is ignored.
- Output reset values: dmem_req=0, dmem_we=0, dmem_be=0, dmem_wdata=0, stallM=0, faultM=0, readdataM=0. While rst=1 all outputs are held at these values regardless of inputs.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, gnt immediate, rvalid +1 -> be unused. Sequence: stall 1,1,0; DONE readdataM=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH, addr 0x2002, wd 0x0000_BEEF -> dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, addr 0x2000; stallM 1 then 0.
- LW, addr 0x40, gnt low 3 cycles, rvalid 2 cycles after gnt -> req stable 4 cycles; stallM=1 until DONE; readdataM=rdata; exactly one gnt-accepted request.
- LW at 0x42; then SH at 0x41; then funct3=011 load -> each: faultM=1, dmem_req=0, stallM=0.
- Load in WAIT, rst=1 for one cycle, then rvalid arrives -> state IDLE, stallM=0, readdataM=0, rvalid ignored.
- SW 0x10 followed by LW 0x10 back-to-back -> second request starts the cycle after store DONE; no cycle with dmem_req in DONE.
